// File: rtl/pulse_stretch_driver.sv
// Stretches single-cycle event pulses into fixed ON windows followed by a mandatory OFF gap.
// Define PULSE_QUEUE_EN to queue requests that arrive while busy; otherwise they are dropped.
module pulse_stretch_driver #(
  parameter int ON_CYCLES  = 8,
  parameter int OFF_CYCLES = 8,
  parameter int CNT_W      = 16,
  parameter int QDEPTH_W   = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_pulse,
  output logic                o_out,
  output logic                o_busy,
  output logic                o_drop,
  output logic [QDEPTH_W-1:0] o_pending
);

  typedef enum logic [1:0] {IDLE, ON, GAP} state_t;

  localparam logic [CNT_W-1:0] ON_LOAD  = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] OFF_LOAD = CNT_W'(OFF_CYCLES - 1);

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             out_reg;
  logic             busy_reg;
  logic             drop_reg;
  logic             cnt_zero;
  logic             gap_done;
  logic             start_next;
  logic             drop_next;

  assign cnt_zero = (cnt_reg == '0);
  assign gap_done = (state_reg == GAP) && cnt_zero;

`ifdef PULSE_QUEUE_EN
  localparam logic [QDEPTH_W-1:0] PEND_MAX = '1;

  logic [QDEPTH_W-1:0] pend_reg;
  logic [QDEPTH_W-1:0] pend_next;
  logic                has_pend;
  logic                enq;
  logic                deq;

  // A fresh request at the end of a gap with nothing queued starts directly
  // instead of being queued; with something queued, the oldest one wins.
  always_comb begin
    has_pend   = (pend_reg != '0);
    start_next = ((state_reg == IDLE) || gap_done) && (i_pulse || has_pend);
    deq        = start_next && has_pend && !((state_reg == IDLE) && i_pulse);
    enq        = i_pulse && (state_reg != IDLE) && !(gap_done && !has_pend);
    pend_next  = pend_reg;
    drop_next  = 1'b0;
    if (enq && !deq) begin
      if (pend_reg == PEND_MAX) begin
        drop_next = 1'b1;
      end else begin
        pend_next = pend_reg + 1'b1;
      end
    end else if (deq && !enq) begin
      pend_next = pend_reg - 1'b1;
    end
  end

  assign o_pending = pend_reg;
`else
  always_comb begin
    start_next = (state_reg == IDLE) && i_pulse;
    drop_next  = (state_reg != IDLE) && i_pulse;
  end

  assign o_pending = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      out_reg   <= 1'b0;
      busy_reg  <= 1'b0;
      drop_reg  <= 1'b0;
`ifdef PULSE_QUEUE_EN
      pend_reg  <= '0;
`endif
    end else begin
      drop_reg <= drop_next;
`ifdef PULSE_QUEUE_EN
      pend_reg <= pend_next;
`endif
      case (state_reg)
        IDLE, GAP: begin
          if (start_next) begin
            state_reg <= ON;
            cnt_reg   <= ON_LOAD;
            out_reg   <= 1'b1;
            busy_reg  <= 1'b1;
          end else if (state_reg == GAP) begin
            if (cnt_zero) begin
              state_reg <= IDLE;
              busy_reg  <= 1'b0;
            end else begin
              cnt_reg <= cnt_reg - 1'b1;
            end
          end
        end
        ON: begin
          if (cnt_zero) begin
            state_reg <= GAP;
            cnt_reg   <= OFF_LOAD;
            out_reg   <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
          cnt_reg   <= '0;
          out_reg   <= 1'b0;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign o_out  = out_reg;
  assign o_busy = busy_reg;
  assign o_drop = drop_reg;

endmodule

// File: tb/tb_pulse_stretch_driver.sv
// Bench for pulse_stretch_driver (ON=4, OFF=3, QDEPTH_W=2); expectations follow PULSE_QUEUE_EN.
// Scenario masks index by cycle number: cycle c is the value seen just after edge c-1.
module tb_pulse_stretch_driver;

  localparam int QW = 2;
  localparam int NE = 40;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          i_pulse = 1'b0;
  logic          o_out;
  logic          o_busy;
  logic          o_drop;
  logic [QW-1:0] o_pending;

  always #5 clk = ~clk;

  pulse_stretch_driver #(
    .ON_CYCLES (4),
    .OFF_CYCLES(3),
    .CNT_W     (16),
    .QDEPTH_W  (QW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .i_pulse  (i_pulse),
    .o_out    (o_out),
    .o_busy   (o_busy),
    .o_drop   (o_drop),
    .o_pending(o_pending)
  );

  typedef logic [63:0] mask_t;

  typedef struct {
    string name;
    mask_t rst;
    mask_t pulse;
    mask_t out;
    mask_t busy;
    mask_t drop;
    mask_t pend0;
    mask_t pend1;
  } scen_t;

  typedef struct {
    logic          out;
    logic          busy;
    logic          drop;
    logic [QW-1:0] pend;
    int            cyc;
  } exp_t;

  scen_t scen[$];
  exp_t  sb[$];
  int    checks = 0;
  int    errors = 0;

  function automatic mask_t rng(input int lo, input int hi);
    mask_t m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  function automatic mask_t at(input int e);
    return rng(e, e);
  endfunction

  task automatic add(input string n, input mask_t rs, input mask_t p, input mask_t o,
                     input mask_t b, input mask_t d, input mask_t p0, input mask_t p1);
    scen_t s;
    s.name = n; s.rst = rs; s.pulse = p; s.out = o;
    s.busy = b; s.drop = d; s.pend0 = p0; s.pend1 = p1;
    scen.push_back(s);
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp, input int cyc);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input scen_t s);
    exp_t e;
    exp_t got;
    for (int k = 0; k < NE; k++) begin
      reset   = (k == 0) || s.rst[k];
      i_pulse = s.pulse[k];
      e.out   = s.out[k+1];
      e.busy  = s.busy[k+1];
      e.drop  = s.drop[k+1];
      e.pend  = {s.pend1[k+1], s.pend0[k+1]};
      e.cyc   = k + 1;
      sb.push_back(e);
      tick();
      got = sb.pop_front();
      check({s.name, ".out"},     32'(o_out),     32'(got.out),  got.cyc);
      check({s.name, ".busy"},    32'(o_busy),    32'(got.busy), got.cyc);
      check({s.name, ".drop"},    32'(o_drop),    32'(got.drop), got.cyc);
      check({s.name, ".pending"}, 32'(o_pending), 32'(got.pend), got.cyc);
    end
    reset   = 1'b0;
    i_pulse = 1'b0;
    $display("scenario %s done: %0d checks, %0d errors so far", s.name, checks, errors);
  endtask

  initial begin
    int rises;
    int drops;
    int run_len;
    logic prev;

`ifdef PULSE_QUEUE_EN
    add("single", '0, at(10), rng(11,14), rng(11,17), '0, '0, '0);
    add("three", '0, at(10)|at(12)|at(13), rng(11,14)|rng(18,21)|rng(25,28), rng(11,31),
        '0, at(13)|rng(18,24), rng(14,17));
    add("saturate", '0, rng(10,14), rng(11,14)|rng(18,21)|rng(25,28)|rng(32,35), rng(11,38),
        at(15), at(12)|rng(14,17)|rng(25,31), rng(13,24));
    add("gap_pend", '0, at(10)|at(12)|at(17), rng(11,14)|rng(18,21)|rng(25,28), rng(11,31),
        '0, rng(13,24), '0);
    add("gap_direct", '0, at(10)|at(17), rng(11,14)|rng(18,21), rng(11,24), '0, '0, '0);
    add("reset_mid_on", at(12), at(8)|at(9)|at(10)|at(20), rng(9,12)|rng(21,24),
        rng(9,12)|rng(21,27), '0, at(10), rng(11,12));
`else
    add("single", '0, at(10), rng(11,14), rng(11,17), '0, '0, '0);
    add("drop_on", '0, at(10)|at(12), rng(11,14), rng(11,17), at(13), '0, '0);
    add("drop_lastgap", '0, at(10)|at(17)|at(18), rng(11,14)|rng(19,22),
        rng(11,17)|rng(19,25), at(18), '0, '0);
    add("burst", '0, rng(10,14), rng(11,14), rng(11,17), rng(12,15), '0, '0);
    add("reset_mid_on", at(12), at(8)|at(9)|at(10)|at(20), rng(9,12)|rng(21,24),
        rng(9,12)|rng(21,27), rng(10,11), '0, '0);
`endif

    // Reset held with i_pulse high: requests are ignored and outputs stay cleared.
    reset   = 1'b1;
    i_pulse = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("rst.out",     32'(o_out),     32'd0, k);
      check("rst.busy",    32'(o_busy),    32'd0, k);
      check("rst.drop",    32'(o_drop),    32'd0, k);
      check("rst.pending", 32'(o_pending), 32'd0, k);
    end
    i_pulse = 1'b0;

    foreach (scen[i]) run(scen[i]);

    // Continuous request stream: count ON windows and drops, verify window width.
    reset = 1'b1;
    tick();
    reset   = 1'b0;
    rises   = 0;
    drops   = 0;
    run_len = 0;
    prev    = 1'b0;
    for (int k = 0; k < 56; k++) begin
      i_pulse = (k < 28);
      tick();
      if (o_out) begin
        run_len++;
      end else if (prev) begin
        check("stream.on_width", 32'(run_len), 32'd4, k + 1);
        run_len = 0;
      end
      if (o_out && !prev) rises++;
      if (o_drop) drops++;
      prev = o_out;
    end
    i_pulse = 1'b0;
`ifdef PULSE_QUEUE_EN
    check("stream.windows", 32'(rises), 32'd7, 56);
    check("stream.drops",   32'(drops), 32'd21, 56);
`else
    check("stream.windows", 32'(rises), 32'd4, 56);
    check("stream.drops",   32'(drops), 32'd24, 56);
`endif
    check("stream.busy_end",    32'(o_busy),    32'd0, 56);
    check("stream.pending_end", 32'(o_pending), 32'd0, 56);
    $display("stream done: windows=%0d drops=%0d", rises, drops);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pulse_stretch_driver.md
# pulse_stretch_driver

Output-side counterpart to the button conditioning path: accepts single-cycle event pulses from internal logic and drives a clean, minimum-width level for an LED, buzzer or Braille actuator pin. Each request produces exactly one ON window followed by a mandatory OFF gap, so the external device never sees glitches or merged pulses. Requests arriving while the output is busy are queued (configurable) or reported as dropped.

## Interface
- ON_CYCLES, 8: output high time per request, in clk cycles; must be >= 1 and fit in CNT_W.
- OFF_CYCLES, 8: mandatory low gap after each ON window, in clk cycles; must be >= 1 and fit in CNT_W.
- CNT_W, 16: width of the internal down-counter.
- QDEPTH_W, 4: width of the pending-request counter; maximum pending is 2^QDEPTH_W - 1.

- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- i_pulse  input  1  request; every cycle sampled high is one request.
- o_out  output  1  registered drive level to the external device.
- o_busy  output  1  registered; high whenever the state is not IDLE.
- o_drop  output  1  registered one-cycle flag: a request was discarded.
- o_pending  output  QDEPTH_W  registered count of queued requests.

## Operation
- States: IDLE, ON, GAP.
- IDLE: on i_pulse, or pending > 0, go to ON, load counter with ON_CYCLES-1. If start comes from pending (no i_pulse), pending decrements.
- ON: o_out = 1. Counter decrements each cycle; at 0 go to GAP, load OFF_CYCLES-1.
- GAP: o_out = 0. At counter 0: if pending > 0 or i_pulse, go directly to ON (no IDLE cycle); else IDLE.
- Requests during ON/GAP (with queue enabled): pending += 1; if pending is already at maximum, request is discarded and o_drop asserts.
- Simultaneous i_pulse and dequeue at end of GAP: the dequeued request starts; the new one is queued; pending unchanged net.
- Pending never wraps; saturates at maximum.
- o_out, o_busy are pure functions of the registered state (no combinational path from i_pulse).

## Timing
- Reset: state IDLE, counter 0, o_out 0, o_busy 0, o_drop 0, o_pending 0. Takes effect at the reset edge, including mid-ON (o_out low the cycle after the reset edge) and discards all pending requests.
- Latency: i_pulse high at edge N (from IDLE) -> o_out high from cycle N+1 for exactly ON_CYCLES cycles, then low for exactly OFF_CYCLES cycles.
- o_busy high from N+1 through the last GAP cycle.
- Back-to-back service: next ON window begins the cycle after the last GAP cycle; period per request = ON_CYCLES + OFF_CYCLES.
- o_drop high for one cycle, the cycle after the discarded i_pulse edge.
- o_pending updates the cycle after the enqueue/dequeue edge.

## Configuration
- PULSE_QUEUE_EN defined: pending counter implemented as above.
- PULSE_QUEUE_EN undefined: no pending counter; o_pending tied to 0; any i_pulse while not IDLE (including the last GAP cycle) is discarded and raises o_drop. IDLE behaviour unchanged.

## Test plan
Parameters ON_CYCLES=4, OFF_CYCLES=3, QDEPTH_W=2 unless stated; macro defined unless stated.
- Single pulse at edge 10 -> o_out 1 cycles 11-14, 0 from 15; o_busy 1 cycles 11-17, 0 at 18; o_drop never high.
- Pulses at edges 10, 12, 13 -> o_pending 1 at 13, 2 at 14; o_out high 11-14, 18-21, 25-28; o_pending 1 at 18, 0 at 25; o_busy low at 32.
- Pulses at edges 10,11,12,13,14 -> o_pending saturates at 3 at cycle 14; o_drop high only at cycle 15; exactly four ON windows total.
- Pending=1 and i_pulse on last GAP cycle (cycle 17) -> ON starts at 18 with no IDLE cycle; o_pending stays 1.
- Reset asserted at edge 12 (mid-ON) with pending=2 -> o_out, o_busy, o_pending all 0 at cycle 13; new pulse after reset reproduces the single-pulse timing.
- Macro undefined: pulses at edges 10 and 12 -> one ON window (11-14), o_drop high at cycle 13, o_pending always 0.
